busid_rx_dispatch: RTL and testbench

Receive-side counterpart of the hub's bus-ID transmit selector: accepts one 5-bit CAN bus ID at a time from the CAN receive path and routes it to one of four bus-group ports. Routing uses a one-hot, registered per-port enable held until the addressed port acknowledges. Sits between the CAN frame decoder and the four bus-group handlers. Also provides range checking, an optional acknowledge timeout and a saturating dispatch counter.

---
 rtl/busid_rx_dispatch_if.sv | 26 ++
 rtl/busid_rx_dispatch.sv | 117 +++++++++++
 tb/tb_busid_rx_dispatch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/busid_rx_dispatch_if.sv
// Bus-ID dispatch bus: the upstream ID handshake plus the four per-port enables and acks.
// master is the environment (frame decoder + bus-group handlers), slave is the dispatcher.
interface busid_rx_dispatch_if;
  logic [4:0] busid_in;
  logic       busid_valid;
  logic       busid_ready;
  logic       ack0;
  logic       ack1;
  logic       ack2;
  logic       ack3;
  logic       buffer_en0;
  logic       buffer_en1;
  logic       buffer_en2;
  logic       buffer_en3;
  logic [4:0] busid_out;

  modport master (
    output busid_in, busid_valid, ack0, ack1, ack2, ack3,
    input  busid_ready, buffer_en0, buffer_en1, buffer_en2, buffer_en3, busid_out
  );

  modport slave (
    input  busid_in, busid_valid, ack0, ack1, ack2, ack3,
    output busid_ready, buffer_en0, buffer_en1, buffer_en2, buffer_en3, busid_out
  );
endinterface

// File: rtl/busid_rx_dispatch.sv
// Routes one received CAN bus ID at a time to one of four bus-group ports (port = id[4:3]).
// Define MOPSHUB_BUSID_TIMEOUT_EN to build the acknowledge timeout timer and err_timeout.
module busid_rx_dispatch #(
  parameter int MAX_BUSID      = 31,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  busid_rx_dispatch_if.slave   bus,
  output logic                 err_range,
  output logic                 err_timeout,
  output logic [7:0]           disp_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [5:0] MAX_ID = 6'(MAX_BUSID);

  state_t     state;
  logic       ready;
  logic [1:0] port;
  logic [3:0] en;
  logic [4:0] id_q;
  logic [3:0] ack_vec;
  logic       port_ack;
  logic       id_ok;

  if (MAX_BUSID < 0 || MAX_BUSID > 31) begin : g_bad_max_busid
    $error("busid_rx_dispatch: MAX_BUSID must be 0..31");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("busid_rx_dispatch: TIMEOUT_CYCLES must be 1..65535");
  end

  assign ack_vec  = {bus.ack3, bus.ack2, bus.ack1, bus.ack0};
  assign port_ack = ack_vec[port];
  assign id_ok    = ({1'b0, bus.busid_in} <= MAX_ID);

  assign bus.busid_ready = ready;
  assign bus.buffer_en0  = en[0];
  assign bus.buffer_en1  = en[1];
  assign bus.buffer_en2  = en[2];
  assign bus.buffer_en3  = en[3];
  assign bus.busid_out   = id_q;

`ifdef MOPSHUB_BUSID_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer;
  logic        tmo_q;
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  // ready is a registered copy of "state is IDLE" so it stays low while reset is held
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      port      <= 2'd0;
      en        <= 4'd0;
      id_q      <= 5'd0;
      err_range <= 1'b0;
      disp_cnt  <= 8'd0;
`ifdef MOPSHUB_BUSID_TIMEOUT_EN
      timer     <= 16'd0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      err_range <= 1'b0;
`ifdef MOPSHUB_BUSID_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (bus.busid_valid && ready) begin
            if (id_ok) begin
              state <= ACTIVE;
              ready <= 1'b0;
              id_q  <= bus.busid_in;
              port  <= bus.busid_in[4:3];
              en    <= 4'b0001 << bus.busid_in[4:3];
`ifdef MOPSHUB_BUSID_TIMEOUT_EN
              timer <= 16'd0;
`endif
            end else begin
              err_range <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // an ack arriving on the expiry cycle still counts as a dispatch
          if (port_ack) begin
            state <= IDLE;
            ready <= 1'b1;
            en    <= 4'd0;
            if (disp_cnt != 8'hFF) disp_cnt <= disp_cnt + 8'd1;
          end else begin
`ifdef MOPSHUB_BUSID_TIMEOUT_EN
            if (timer == TMO_LAST) begin
              state <= IDLE;
              ready <= 1'b1;
              en    <= 4'd0;
              tmo_q <= 1'b1;
            end else begin
              timer <= timer + 16'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_busid_rx_dispatch.sv
// Directed-vector bench for busid_rx_dispatch; covers timeout when MOPSHUB_BUSID_TIMEOUT_EN is defined.
// A second instance with MAX_BUSID=20 exercises range rejection.
module tb_busid_rx_dispatch;
  logic        clk;
  logic        rst;
  logic        err_range;
  logic        err_timeout;
  logic [7:0]  disp_cnt;
  logic        err_range_r;
  logic        err_timeout_r;
  logic [7:0]  disp_cnt_r;
  logic [3:0]  en_main;
  logic [3:0]  en_r;

  int vectors     = 0;
  int miscompares = 0;

  busid_rx_dispatch_if bus ();
  busid_rx_dispatch_if bus_r ();

  busid_rx_dispatch #(.MAX_BUSID(31), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .err_range(err_range), .err_timeout(err_timeout), .disp_cnt(disp_cnt)
  );

  busid_rx_dispatch #(.MAX_BUSID(20), .TIMEOUT_CYCLES(4)) dut_r (
    .clk(clk), .rst(rst), .bus(bus_r.slave),
    .err_range(err_range_r), .err_timeout(err_timeout_r), .disp_cnt(disp_cnt_r)
  );

  assign en_main = {bus.buffer_en3, bus.buffer_en2, bus.buffer_en1, bus.buffer_en0};
  assign en_r    = {bus_r.buffer_en3, bus_r.buffer_en2, bus_r.buffer_en1, bus_r.buffer_en0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] id, input logic valid, input logic [3:0] acks);
    bus.busid_in    = id;
    bus.busid_valid = valid;
    {bus.ack3, bus.ack2, bus.ack1, bus.ack0} = acks;
  endtask

  task automatic applyStimulusR(input logic [4:0] id, input logic valid, input logic [3:0] acks);
    bus_r.busid_in    = id;
    bus_r.busid_valid = valid;
    {bus_r.ack3, bus_r.ack2, bus_r.ack1, bus_r.ack0} = acks;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(5'd0, 1'b0, 4'd0);
    applyStimulusR(5'd0, 1'b0, 4'd0);
    tick();
    tick();
    checkOutput("reset_ready", 32'(bus.busid_ready), 32'd0);
    checkOutput("reset_en", 32'(en_main), 32'd0);
    checkOutput("reset_busid_out", 32'(bus.busid_out), 32'd0);
    checkOutput("reset_errs", 32'({err_range, err_timeout}), 32'd0);
    checkOutput("reset_disp_cnt", 32'(disp_cnt), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("ready_after_release", 32'(bus.busid_ready), 32'd1);

    // basic dispatch of ID 10 to port 1
    applyStimulus(5'd10, 1'b1, 4'd0);
    tick();
    checkOutput("id10_en", 32'(en_main), 32'b0010);
    checkOutput("id10_busid_out", 32'(bus.busid_out), 32'd10);
    checkOutput("id10_ready", 32'(bus.busid_ready), 32'd0);
    applyStimulus(5'd10, 1'b0, 4'b0010);
    tick();
    checkOutput("id10_ack_en", 32'(en_main), 32'd0);
    checkOutput("id10_ack_ready", 32'(bus.busid_ready), 32'd1);
    checkOutput("id10_disp_cnt", 32'(disp_cnt), 32'd1);
    checkOutput("id10_busid_out_kept", 32'(bus.busid_out), 32'd10);

    // back-to-back IDs 3 and 31, foreign ack2 ignored while port 3 is enabled
    applyStimulus(5'd3, 1'b1, 4'd0);
    tick();
    checkOutput("id3_en", 32'(en_main), 32'b0001);
    applyStimulus(5'd3, 1'b0, 4'b0001);
    tick();
    checkOutput("id3_ack_en", 32'(en_main), 32'd0);
    checkOutput("id3_ack_ready", 32'(bus.busid_ready), 32'd1);
    applyStimulus(5'd31, 1'b1, 4'd0);
    tick();
    checkOutput("id31_en", 32'(en_main), 32'b1000);
    checkOutput("id31_busid_out", 32'(bus.busid_out), 32'd31);
    checkOutput("id31_no_range_err", 32'(err_range), 32'd0);
    applyStimulus(5'd31, 1'b0, 4'b0100);
    tick();
    checkOutput("id31_ack2_ignored_en", 32'(en_main), 32'b1000);
    checkOutput("id31_ack2_ignored_ready", 32'(bus.busid_ready), 32'd0);
    applyStimulus(5'd31, 1'b0, 4'b1000);
    tick();
    checkOutput("id31_ack_en", 32'(en_main), 32'd0);
    checkOutput("id31_disp_cnt", 32'(disp_cnt), 32'd3);
    applyStimulus(5'd0, 1'b0, 4'd0);

    // range checking on the MAX_BUSID=20 instance
    applyStimulusR(5'd12, 1'b1, 4'd0);
    tick();
    checkOutput("r_id12_busid_out", 32'(bus_r.busid_out), 32'd12);
    applyStimulusR(5'd12, 1'b0, 4'b0010);
    tick();
    applyStimulusR(5'd25, 1'b1, 4'd0);
    tick();
    checkOutput("r_id25_err_range", 32'(err_range_r), 32'd1);
    checkOutput("r_id25_en", 32'(en_r), 32'd0);
    checkOutput("r_id25_busid_out", 32'(bus_r.busid_out), 32'd12);
    checkOutput("r_id25_ready", 32'(bus_r.busid_ready), 32'd1);
    applyStimulusR(5'd25, 1'b0, 4'd0);
    tick();
    checkOutput("r_id25_err_pulse_end", 32'(err_range_r), 32'd0);
    applyStimulusR(5'd20, 1'b1, 4'd0);
    tick();
    checkOutput("r_id20_boundary_en", 32'(en_r), 32'b0100);
    checkOutput("r_id20_no_err", 32'(err_range_r), 32'd0);
    applyStimulusR(5'd20, 1'b0, 4'b0100);
    tick();
    checkOutput("r_disp_cnt", 32'(disp_cnt_r), 32'd2);
    applyStimulusR(5'd0, 1'b0, 4'd0);

`ifdef MOPSHUB_BUSID_TIMEOUT_EN
    // timeout with TIMEOUT_CYCLES=4: enable held exactly 4 cycles
    applyStimulus(5'd17, 1'b1, 4'd0);
    tick();
    checkOutput("tmo_en_c1", 32'(en_main), 32'b0100);
    applyStimulus(5'd17, 1'b0, 4'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("tmo_en_c%0d", i), 32'(en_main), 32'b0100);
      checkOutput($sformatf("tmo_no_err_c%0d", i), 32'(err_timeout), 32'd0);
    end
    tick();
    checkOutput("tmo_en_dropped", 32'(en_main), 32'd0);
    checkOutput("tmo_err_pulse", 32'(err_timeout), 32'd1);
    checkOutput("tmo_disp_unchanged", 32'(disp_cnt), 32'd3);
    checkOutput("tmo_ready", 32'(bus.busid_ready), 32'd1);
    tick();
    checkOutput("tmo_err_pulse_end", 32'(err_timeout), 32'd0);
    applyStimulus(5'd17, 1'b1, 4'd0);
    tick();
    applyStimulus(5'd17, 1'b0, 4'd0);
    tick();
    tick();
    tick();
    applyStimulus(5'd17, 1'b0, 4'b0100);
    tick();
    checkOutput("tmo_ack_wins_en", 32'(en_main), 32'd0);
    checkOutput("tmo_ack_wins_err", 32'(err_timeout), 32'd0);
    checkOutput("tmo_ack_wins_disp", 32'(disp_cnt), 32'd4);
`else
    // no timer built: enable waits for ack indefinitely
    applyStimulus(5'd17, 1'b1, 4'd0);
    tick();
    applyStimulus(5'd17, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("notmo_en_held", 32'(en_main), 32'b0100);
    checkOutput("notmo_err_timeout", 32'(err_timeout), 32'd0);
    applyStimulus(5'd17, 1'b0, 4'b0100);
    tick();
    checkOutput("notmo_ack_en", 32'(en_main), 32'd0);
    checkOutput("notmo_disp", 32'(disp_cnt), 32'd4);
`endif
    applyStimulus(5'd0, 1'b0, 4'd0);
    tick();

    // reset while port 2 is enabled
    applyStimulus(5'd18, 1'b1, 4'd0);
    tick();
    checkOutput("rstmid_en_before", 32'(en_main), 32'b0100);
    applyStimulus(5'd18, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    checkOutput("rstmid_en", 32'(en_main), 32'd0);
    checkOutput("rstmid_busid_out", 32'(bus.busid_out), 32'd0);
    checkOutput("rstmid_disp", 32'(disp_cnt), 32'd0);
    checkOutput("rstmid_errs", 32'({err_range, err_timeout}), 32'd0);
    checkOutput("rstmid_ready", 32'(bus.busid_ready), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rstmid_ready_after", 32'(bus.busid_ready), 32'd1);

    // 300 acknowledged dispatches saturate the counter at 255
    for (int i = 0; i < 300; i++) begin
      logic [4:0] id;
      id = 5'(i);
      applyStimulus(id, 1'b1, 4'd0);
      tick();
      applyStimulus(id, 1'b0, 4'b0001 << id[4:3]);
      tick();
      if (i == 199) checkOutput("sat_cnt_200", 32'(disp_cnt), 32'd200);
      if (i == 254) checkOutput("sat_cnt_255", 32'(disp_cnt), 32'd255);
    end
    applyStimulus(5'd0, 1'b0, 4'd0);
    tick();
    checkOutput("sat_cnt_300", 32'(disp_cnt), 32'd255);
    checkOutput("sat_idle_en", 32'(en_main), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
